// File: rtl/tb_stream_pkg.sv
// Shared types and helpers for the tb_stream_buffer valid/ready FIFO.
// Optional feature macro: TB_STREAM_BUF_PARITY_EN (per-entry even parity).

// Storage entry layout. Packages cannot take parameters, so the payload
// width is supplied at the point of use.
`define TB_STREAM_ENTRY_T(W) struct packed { logic [(W)-1:0] data; logic par; }

package tb_stream_pkg;

  // Address width for a given depth; never returns zero so slices stay legal.
  function automatic int addr_w_f(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Coarse occupancy class derived from the pointers.
  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_MID,
    ST_FULL
  } occ_e;

endpackage

// File: rtl/tb_stream_mem.sv
// DEPTH x WIDTH register array with one synchronous write port and one
// combinational read port. Contents are deliberately not reset.

module tb_stream_mem import tb_stream_pkg::*; #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [addr_w_f(DEPTH)-1:0]  waddr,
  input  logic [WIDTH-1:0]            wdata,
  input  logic [addr_w_f(DEPTH)-1:0]  raddr,
  output logic [WIDTH-1:0]            rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Store the incoming entry on a write strobe.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/tb_stream_buffer.sv
// Parametrised valid/ready stream FIFO with first-word-fall-through head,
// registered level / almost_full, synchronous flush and optional parity.
// Optional feature macro: TB_STREAM_BUF_PARITY_EN.

module tb_stream_buffer import tb_stream_pkg::*; #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int AFULL_TH = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_data,
  input  logic                     s_err_inj,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_W-1:0]        m_data,
  output logic                     m_par_err,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     almost_full
);

  localparam int ADDR_W = addr_w_f(DEPTH);
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  // Parameter sanity checks at elaboration time.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("tb_stream_buffer: DEPTH must be a power of two >= 2");
  end
  if ((AFULL_TH < 1) || (AFULL_TH > DEPTH)) begin : g_bad_afull
    $error("tb_stream_buffer: AFULL_TH must lie in 1..DEPTH");
  end

`ifdef TB_STREAM_BUF_PARITY_EN
  typedef `TB_STREAM_ENTRY_T(DATA_W) entry_t;
  localparam int MEM_W = $bits(entry_t);
`else
  localparam int MEM_W = DATA_W;
`endif

  logic [ADDR_W:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             almost_full_q, almost_full_d;
  logic             empty, full, push, pop;
  occ_e             occ;
  logic [MEM_W-1:0] mem_wdata, mem_rdata;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

  // Classify occupancy from the registered pointers only.
  always_comb begin
    occ = ST_MID;
    if (empty) begin
      occ = ST_EMPTY;
    end else if (full) begin
      occ = ST_FULL;
    end
  end

  assign s_ready = (occ != ST_FULL);
  assign m_valid = (occ != ST_EMPTY);

  // Flush discards any handshake that happens in the same cycle.
  assign push = s_valid && s_ready && !flush;
  assign pop  = m_valid && m_ready && !flush;

  // Next pointers, level and almost_full; flush wins over push and pop.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    almost_full_d = almost_full_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + (ADDR_W + 1)'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + (ADDR_W + 1)'(1);
      end
      if (push && !pop) begin
        level_d = level_q + LVL_W'(1);
      end else if (pop && !push) begin
        level_d = level_q - LVL_W'(1);
      end
    end
    almost_full_d = (level_d >= LVL_W'(AFULL_TH));
  end

  // State registers; async reset empties the FIFO immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      almost_full_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      almost_full_q <= almost_full_d;
    end
  end

  assign level       = level_q;
  assign almost_full = almost_full_q;

`ifdef TB_STREAM_BUF_PARITY_EN
  entry_t wr_entry, rd_entry;

  // Build the stored entry: even parity, optionally corrupted on request.
  always_comb begin
    wr_entry      = '0;
    wr_entry.data = s_data;
    wr_entry.par  = (^s_data) ^ s_err_inj;
  end

  assign mem_wdata = wr_entry;
  assign rd_entry  = entry_t'(mem_rdata);
  assign m_data    = rd_entry.data;
  assign m_par_err = m_valid && ((^rd_entry.data) != rd_entry.par);
`else
  logic unused_err_inj;

  assign unused_err_inj = s_err_inj;
  assign mem_wdata      = s_data;
  assign m_data         = mem_rdata;
  assign m_par_err      = 1'b0;
`endif

  tb_stream_mem #(
    .WIDTH (MEM_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata (mem_wdata),
    .raddr (rd_ptr_q[ADDR_W-1:0]),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_tb_stream_buffer.sv
// Directed, table-driven bench for tb_stream_buffer (DATA_W=8, DEPTH=8, AFULL_TH=6).
// Parity expectations follow TB_STREAM_BUF_PARITY_EN when it is defined.

module tb_tb_stream_buffer;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_err_inj;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_par_err;
  logic [3:0] level;
  logic       almost_full;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       flush;
    logic       s_valid;
    logic [7:0] s_data;
    logic       m_ready;
    logic       exp_s_ready;
    logic       exp_m_valid;
    logic       chk_data;
    logic [7:0] exp_m_data;
    logic [3:0] exp_level;
    logic       exp_afull;
  } vec_t;

  vec_t vecs[19];

  tb_stream_buffer #(
    .DATA_W   (8),
    .DEPTH    (8),
    .AFULL_TH (6)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_err_inj   (s_err_inj),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_par_err   (m_par_err),
    .level       (level),
    .almost_full (almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source-side protocol: a stalled beat must keep its payload.
  logic       prev_stall;
  logic [7:0] prev_data;
  always @(posedge clk) begin
    if (rst_n && prev_stall && s_valid) begin
      assert (s_data == prev_data) else $error("[TB] s_data changed while stalled");
    end
    prev_stall <= rst_n && s_valid && !s_ready;
    prev_data  <= s_data;
  end

  function automatic vec_t mkVec(input logic fl, input logic sv, input logic [7:0] sd,
                                 input logic mr, input logic esr, input logic emv,
                                 input logic cd, input logic [7:0] emd,
                                 input logic [3:0] elv, input logic eaf);
    vec_t v;
    v.flush = fl; v.s_valid = sv; v.s_data = sd; v.m_ready = mr;
    v.exp_s_ready = esr; v.exp_m_valid = emv; v.chk_data = cd;
    v.exp_m_data = emd; v.exp_level = elv; v.exp_afull = eaf;
    return v;
  endfunction

  task automatic applyStimulus(input logic fl, input logic sv, input logic [7:0] sd,
                               input logic ei, input logic mr);
    flush     = fl;
    s_valid   = sv;
    s_data    = sd;
    s_err_inj = ei;
    m_ready   = mr;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdleEmpty(input string tag);
    checkOutput({tag, ".s_ready"}, 32'(s_ready), 32'd1);
    checkOutput({tag, ".m_valid"}, 32'(m_valid), 32'd0);
    checkOutput({tag, ".level"}, 32'(level), 32'd0);
    checkOutput({tag, ".almost_full"}, 32'(almost_full), 32'd0);
    checkOutput({tag, ".m_par_err"}, 32'(m_par_err), 32'd0);
  endtask

  initial begin
    // Fill 0x11..0x18 without draining, try to push into a full FIFO, then drain.
    vecs[0]  = mkVec(0, 1, 8'h11, 0, 1, 0, 0, 8'h00, 4'd0, 0);
    vecs[1]  = mkVec(0, 1, 8'h12, 0, 1, 1, 1, 8'h11, 4'd1, 0);
    vecs[2]  = mkVec(0, 1, 8'h13, 0, 1, 1, 1, 8'h11, 4'd2, 0);
    vecs[3]  = mkVec(0, 1, 8'h14, 0, 1, 1, 1, 8'h11, 4'd3, 0);
    vecs[4]  = mkVec(0, 1, 8'h15, 0, 1, 1, 1, 8'h11, 4'd4, 0);
    vecs[5]  = mkVec(0, 1, 8'h16, 0, 1, 1, 1, 8'h11, 4'd5, 0);
    vecs[6]  = mkVec(0, 1, 8'h17, 0, 1, 1, 1, 8'h11, 4'd6, 1);
    vecs[7]  = mkVec(0, 1, 8'h18, 0, 1, 1, 1, 8'h11, 4'd7, 1);
    vecs[8]  = mkVec(0, 1, 8'h99, 0, 0, 1, 1, 8'h11, 4'd8, 1);
    vecs[9]  = mkVec(0, 1, 8'h99, 1, 0, 1, 1, 8'h11, 4'd8, 1);
    vecs[10] = mkVec(0, 0, 8'h00, 1, 1, 1, 1, 8'h12, 4'd7, 1);
    vecs[11] = mkVec(0, 0, 8'h00, 1, 1, 1, 1, 8'h13, 4'd6, 1);
    vecs[12] = mkVec(0, 0, 8'h00, 1, 1, 1, 1, 8'h14, 4'd5, 0);
    vecs[13] = mkVec(0, 0, 8'h00, 1, 1, 1, 1, 8'h15, 4'd4, 0);
    vecs[14] = mkVec(0, 0, 8'h00, 1, 1, 1, 1, 8'h16, 4'd3, 0);
    vecs[15] = mkVec(0, 0, 8'h00, 1, 1, 1, 1, 8'h17, 4'd2, 0);
    vecs[16] = mkVec(0, 0, 8'h00, 1, 1, 1, 1, 8'h18, 4'd1, 0);
    vecs[17] = mkVec(0, 0, 8'h00, 1, 1, 0, 0, 8'h00, 4'd0, 0);
    vecs[18] = mkVec(0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 4'd0, 0);

    prev_stall = 1'b0;
    prev_data  = 8'h00;
    applyStimulus(0, 0, 8'h00, 0, 0);
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checkIdleEmpty("reset_async");
    nextCycle();
    nextCycle();
    rst_n = 1'b1;
    nextCycle();
    nextCycle();
    checkIdleEmpty("idle_after_reset");

    $display("[TB] fill/drain table");
    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].flush, vecs[i].s_valid, vecs[i].s_data, 1'b0, vecs[i].m_ready);
      #1;
      checkOutput($sformatf("vec%0d.s_ready", i), 32'(s_ready), 32'(vecs[i].exp_s_ready));
      checkOutput($sformatf("vec%0d.m_valid", i), 32'(m_valid), 32'(vecs[i].exp_m_valid));
      checkOutput($sformatf("vec%0d.level", i), 32'(level), 32'(vecs[i].exp_level));
      checkOutput($sformatf("vec%0d.almost_full", i), 32'(almost_full), 32'(vecs[i].exp_afull));
      if (vecs[i].chk_data) begin
        checkOutput($sformatf("vec%0d.m_data", i), 32'(m_data), 32'(vecs[i].exp_m_data));
        checkOutput($sformatf("vec%0d.m_par_err", i), 32'(m_par_err), 32'd0);
      end
      nextCycle();
    end

    $display("[TB] streaming 100 beats");
    for (int i = 0; i <= 100; i++) begin
      applyStimulus(0, (i < 100), 8'(8'h20 + i), 0, 1);
      #1;
      checkOutput($sformatf("stream%0d.s_ready", i), 32'(s_ready), 32'd1);
      if (i == 0) begin
        checkOutput("stream0.m_valid", 32'(m_valid), 32'd0);
        checkOutput("stream0.level", 32'(level), 32'd0);
      end else begin
        checkOutput($sformatf("stream%0d.m_valid", i), 32'(m_valid), 32'd1);
        checkOutput($sformatf("stream%0d.level", i), 32'(level), 32'd1);
        checkOutput($sformatf("stream%0d.m_data", i), 32'(m_data), 32'(8'(8'h20 + i - 1)));
      end
      nextCycle();
    end
    applyStimulus(0, 0, 8'h00, 0, 0);
    checkIdleEmpty("stream_end");

    $display("[TB] flush with concurrent beat");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 8'(8'h41 + i), 0, 0);
      nextCycle();
    end
    applyStimulus(1, 1, 8'hAA, 0, 0);
    #1;
    checkOutput("flush.s_ready", 32'(s_ready), 32'd1);
    checkOutput("flush.level_before", 32'(level), 32'd5);
    nextCycle();
    applyStimulus(0, 0, 8'h00, 0, 1);
    checkIdleEmpty("flush_after");
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkOutput($sformatf("flush_quiet%0d.m_valid", i), 32'(m_valid), 32'd0);
    end

    $display("[TB] async reset mid-transfer");
    applyStimulus(0, 0, 8'h00, 0, 0);
    nextCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 8'(8'h61 + i), 0, 0);
      nextCycle();
    end
    applyStimulus(0, 0, 8'h00, 0, 0);
    checkOutput("rst_mid.level_before", 32'(level), 32'd3);
    checkOutput("rst_mid.m_data_before", 32'(m_data), 32'h61);
    #2;
    rst_n = 1'b0;
    #1;
    checkIdleEmpty("rst_mid");
    nextCycle();
    rst_n = 1'b1;
    applyStimulus(0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkOutput($sformatf("rst_release%0d.m_valid", i), 32'(m_valid), 32'd0);
      checkOutput($sformatf("rst_release%0d.level", i), 32'(level), 32'd0);
    end

    $display("[TB] parity injection");
    applyStimulus(0, 1, 8'h3C, 1, 0);
    nextCycle();
    applyStimulus(0, 1, 8'h3D, 0, 0);
    nextCycle();
    applyStimulus(0, 0, 8'h00, 0, 1);
    #1;
    checkOutput("par0.m_data", 32'(m_data), 32'h3C);
`ifdef TB_STREAM_BUF_PARITY_EN
    checkOutput("par0.m_par_err", 32'(m_par_err), 32'd1);
`else
    checkOutput("par0.m_par_err", 32'(m_par_err), 32'd0);
`endif
    nextCycle();
    applyStimulus(0, 0, 8'h00, 0, 1);
    checkOutput("par1.m_data", 32'(m_data), 32'h3D);
    checkOutput("par1.m_par_err", 32'(m_par_err), 32'd0);
    nextCycle();
    applyStimulus(0, 0, 8'h00, 0, 0);
    checkIdleEmpty("par_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
